// File: rtl/uart_console_pkg.sv
// Shared definitions for the UART console.
//   UART_EMPTY_CH   : character returned to the core when nothing is buffered
//   UART_FIFO_DEPTH : default entries per FIFO (power of two, >= 2)
//   uart_ch_t       : one console character
//   sat_inc16       : saturating 16-bit increment used by the drop counter
package uart_console_pkg;

  localparam logic [7:0] UART_EMPTY_CH   = 8'hFF;
  localparam int         UART_FIFO_DEPTH = 8;

  typedef logic [7:0] uart_ch_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

endpackage

// File: rtl/uart_console_fifo.sv
// uart_fifo: first-word fall-through character FIFO.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (pointers only)
//   i_push     : write i_data (accepted when not full, or when a pop happens too)
//   i_data     : character to write
//   i_pop      : remove head (ignored when empty)
//   o_full     : DEPTH entries held
//   o_empty    : no entries held
//   o_head     : oldest entry (valid only when !o_empty)
module uart_fifo
  import uart_console_pkg::*;
#(
  parameter int DEPTH = UART_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic       o_full,
  output logic       o_empty,
  output logic [7:0] o_head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Storage carries no reset; only the pointers define what is valid.
  logic [7:0]  r_mem [DEPTH];
  // One extra MSB distinguishes full from empty when the address bits match.
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        w_push;
  logic        w_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                   (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_pop   = i_pop && !o_empty;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

  // Write the pushed character into the slot at the write pointer.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
  end

  // Advance pointers; they wrap naturally modulo 2*DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/uart_console.sv
// uart_console: buffers characters between a core and a host link.
// Ports:
//   clk, rst_n                : clock, asynchronous active-low reset
//   uart_out_valid/uart_out_ch: core writes a character (into TX FIFO)
//   uart_in_valid/uart_in_ch  : core reads a character (from RX FIFO, 8'hFF if empty)
//   tx_valid/tx_data/tx_ready : host-side TX stream (first-word fall-through)
//   rx_valid/rx_data/rx_ready : host-side RX stream
//   tx_drop_cnt               : saturating count of core writes lost to a full TX FIFO
//   rx_empty                  : RX FIFO holds nothing
module uart_console
  import uart_console_pkg::*;
#(
  parameter int DEPTH = UART_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_out_valid,
  input  logic [7:0]  uart_out_ch,
  input  logic        uart_in_valid,
  output logic [7:0]  uart_in_ch,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic [15:0] tx_drop_cnt,
  output logic        rx_empty
);

  logic     r_rst_sync;
  logic     w_rst_n;
  logic     w_tx_full;
  logic     w_tx_empty;
  logic     w_tx_push;
  logic     w_tx_pop;
  uart_ch_t w_tx_head;
  logic     w_rx_full;
  logic     w_rx_empty;
  logic     w_rx_push;
  logic     w_rx_pop;
  uart_ch_t w_rx_head;
  logic [15:0] r_drop_cnt;

  // Reset asserts immediately; release is taken on the next clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_sync <= 1'b0;
    end else begin
      r_rst_sync <= 1'b1;
    end
  end

  assign w_rst_n = r_rst_sync;

  assign w_tx_pop  = !w_tx_empty && tx_ready;
  assign w_tx_push = uart_out_valid;
  assign w_rx_push = rx_valid && rx_ready;
  assign w_rx_pop  = uart_in_valid && !w_rx_empty;

  uart_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .clk     (clk),
    .rst_n   (w_rst_n),
    .i_push  (w_tx_push),
    .i_data  (uart_out_ch),
    .i_pop   (w_tx_pop),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_head  (w_tx_head)
  );

  uart_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst_n   (w_rst_n),
    .i_push  (w_rx_push),
    .i_data  (rx_data),
    .i_pop   (w_rx_pop),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_head  (w_rx_head)
  );

  // Count core writes refused because TX is full and nothing drains this cycle.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_drop_cnt <= 16'd0;
    end else if (uart_out_valid && w_tx_full && !w_tx_pop) begin
      r_drop_cnt <= sat_inc16(r_drop_cnt);
    end
  end

  assign tx_drop_cnt = r_drop_cnt;
  assign tx_valid    = !w_tx_empty;
  // Hide uninitialised storage when nothing is queued.
  assign tx_data     = w_tx_empty ? 8'h00 : w_tx_head;
  // The FIFO reads not-full while held in reset, so gate explicitly.
  assign rx_ready    = r_rst_sync && !w_rx_full;
  assign rx_empty    = w_rx_empty;
  assign uart_in_ch  = (r_rst_sync && !w_rx_empty) ? w_rx_head : UART_EMPTY_CH;

endmodule
